// File: rtl/fechadura_pkg.sv
// Shared keypad types and constants for the lock front end: key codes,
// digit buffer layout and debouncer states.
package fechadura_pkg;

   localparam int NUM_DIGITS = 20;

   localparam logic [3:0] DIGIT_EMPTY = 4'hF;
   localparam logic [3:0] KEY_NONE    = 4'hF;
   localparam logic [3:0] KEY_ENTER   = 4'hA;
   localparam logic [3:0] KEY_ERASE   = 4'hB;

   // digits[0] is the most recently entered digit
   typedef logic [NUM_DIGITS-1:0][3:0] senhaPac_t;

   localparam senhaPac_t SENHA_EMPTY = {NUM_DIGITS{DIGIT_EMPTY}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS_DB,
      ST_HELD,
      ST_RELEASE_DB
   } db_state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Debounces raw keypad codes; one registered key_event per stable press, no auto-repeat.
// Event appears the cycle after the DEBOUNCE_CYCLES-th matching sample; enable low forces IDLE.
module key_debouncer
   import fechadura_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [3:0] tecla_value,
   output logic       key_event,
   output logic [3:0] key_code,
   output logic       key_idle
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   db_state_t     state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [3:0]    code_nxt;
   logic          event_nxt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         key_code  <= KEY_NONE;
         key_event <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         key_code  <= code_nxt;
         key_event <= event_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      code_nxt  = key_code;
      event_nxt = 1'b0;
      if (!enable) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tecla_value != KEY_NONE) begin
                  state_nxt = ST_PRESS_DB;
                  code_nxt  = tecla_value;
                  cnt_nxt   = CNT_ONE;
               end
            end
            ST_PRESS_DB: begin
               if (tecla_value == KEY_NONE) begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end else if (tecla_value != key_code) begin
                  code_nxt = tecla_value;
                  cnt_nxt  = CNT_ONE;
               end else if (cnt + CNT_ONE == CNT_DONE) begin
                  event_nxt = 1'b1;
                  state_nxt = ST_HELD;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            ST_HELD: begin
               if (tecla_value == KEY_NONE) begin
                  state_nxt = ST_RELEASE_DB;
                  cnt_nxt   = CNT_ONE;
               end
            end
            ST_RELEASE_DB: begin
               if (tecla_value != KEY_NONE) begin
                  state_nxt = ST_HELD;
                  cnt_nxt   = '0;
               end else if (cnt + CNT_ONE == CNT_DONE) begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign key_idle = (state == ST_IDLE);

endmodule

// File: rtl/keypad_collector.sv
// Collects debounced digits into a shift buffer; '*' submits with a 1-cycle strobe, '#' erases.
// Buffer updates the edge after key_event; optional idle flush under KEYPAD_TIMEOUT_EN.
module keypad_collector
   import fechadura_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [3:0] tecla_value,
   output senhaPac_t  digitos_value,
   output logic       digitos_valid,
   output logic [4:0] digitos_count
);

   localparam logic [4:0] COUNT_FULL = 5'(NUM_DIGITS);

   logic       key_event;
   logic [3:0] key_code;
   logic       key_idle;
   logic       timeout_hit;
   senhaPac_t  entry_q;

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .tecla_value (tecla_value),
      .key_event   (key_event),
      .key_code    (key_code),
      .key_idle    (key_idle)
   );

`ifdef KEYPAD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;

   // Counts only while a partial entry sits untouched with no key down
   always_ff @(posedge clk) begin
      if (!rst) begin
         idle_cnt <= '0;
      end else if (!enable || key_event || digitos_count == 5'd0 || !key_idle || timeout_hit) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + TW'(1);
      end
   end

   assign timeout_hit = enable && !key_event && key_idle && (digitos_count != 5'd0)
                        && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   logic unused_key_idle;
   assign unused_key_idle = key_idle;
   assign timeout_hit     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         entry_q       <= SENHA_EMPTY;
         digitos_count <= '0;
         digitos_value <= SENHA_EMPTY;
         digitos_valid <= 1'b0;
      end else begin
         digitos_valid <= 1'b0;
         if (!enable) begin
            entry_q       <= SENHA_EMPTY;
            digitos_count <= '0;
         end else if (key_event) begin
            if (is_digit(key_code)) begin
               entry_q <= {entry_q[NUM_DIGITS-2:0], key_code};
               if (digitos_count != COUNT_FULL)
                  digitos_count <= digitos_count + 5'd1;
            end else if (key_code == KEY_ENTER && digitos_count != 5'd0) begin
               digitos_value <= entry_q;
               digitos_valid <= 1'b1;
               entry_q       <= SENHA_EMPTY;
               digitos_count <= '0;
            end else if (key_code == KEY_ERASE && digitos_count != 5'd0) begin
               entry_q       <= {DIGIT_EMPTY, entry_q[NUM_DIGITS-1:1]};
               digitos_count <= digitos_count - 5'd1;
            end
         end else if (timeout_hit) begin
            entry_q       <= SENHA_EMPTY;
            digitos_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_collector.sv
// Directed bench for keypad_collector with a submit scoreboard checked on every strobe.
module tb_keypad_collector;
   import fechadura_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] tecla_value = KEY_NONE;
   senhaPac_t  digitos_value;
   logic       digitos_valid;
   logic [4:0] digitos_count;

   int n_cmp = 0;
   int n_err = 0;
   int n_strobe = 0;
   int s0;

   senhaPac_t exp_q[$];
   senhaPac_t exp_v;
   senhaPac_t mdl = SENHA_EMPTY;
   int        mcnt = 0;
   logic      prev_valid = 1'b0;

   always #5 clk = ~clk;

   keypad_collector #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .tecla_value   (tecla_value),
      .digitos_value (digitos_value),
      .digitos_valid (digitos_valid),
      .digitos_count (digitos_count)
   );

   // Scoreboard: each strobe must match the oldest expected submit
   always @(negedge clk) begin
      if (rst && digitos_valid) begin
         n_strobe++;
         n_cmp++;
         assert (exp_q.size() > 0) else begin
            n_err++;
            $error("FAIL strobe_unexpected observed=%h expected=no strobe", digitos_value);
         end
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_cmp++;
            assert (digitos_value === exp_v) else begin
               n_err++;
               $error("FAIL submit_value observed=%h expected=%h", digitos_value, exp_v);
            end
         end
         n_cmp++;
         assert (prev_valid === 1'b0) else begin
            n_err++;
            $error("FAIL strobe_width observed=%b expected=0 (strobe longer than 1 cycle)", prev_valid);
         end
      end
      prev_valid = digitos_valid;
   end

   task automatic check(input string tag, input int obs, input int expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] k, input int hold, input int gap);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1 tecla_value = k;
      end
      for (int i = 0; i < gap; i++) begin
         @(posedge clk); #1 tecla_value = KEY_NONE;
      end
   endtask

   // Clean debounced press; the reference buffer is updated as the key is driven
   task automatic key(input logic [3:0] k);
      if (k <= 4'd9) begin
         mdl = {mdl[NUM_DIGITS-2:0], k};
         if (mcnt < NUM_DIGITS) mcnt++;
      end else if (k == KEY_ENTER && mcnt > 0) begin
         exp_q.push_back(mdl);
         mdl  = SENHA_EMPTY;
         mcnt = 0;
      end else if (k == KEY_ERASE && mcnt > 0) begin
         mdl = {DIGIT_EMPTY, mdl[NUM_DIGITS-1:1]};
         mcnt--;
      end
      press(k, 6, 6);
   endtask

   task automatic flush();
      @(posedge clk); #1 enable = 1'b0;
      @(posedge clk); #1 enable = 1'b1;
      mdl  = SENHA_EMPTY;
      mcnt = 0;
   endtask

   initial begin
      cycles(3);
      check("reset_count", int'(digitos_count), 0);
      check("reset_valid", int'(digitos_valid), 0);
      check("reset_value_empty", int'(digitos_value === SENHA_EMPTY), 1);
      rst = 1'b1;
      enable = 1'b1;
      cycles(2);

      // 1: three digits then submit
      s0 = n_strobe;
      key(4'd1); key(4'd2); key(4'd3);
      check("t1_count_before_submit", int'(digitos_count), 3);
      key(KEY_ENTER);
      check("t1_strobes", n_strobe - s0, 1);
      check("t1_count_after", int'(digitos_count), 0);
      check("t1_digit0", int'(digitos_value[0]), 3);
      check("t1_digit2", int'(digitos_value[2]), 1);
      check("t1_digit3_empty", int'(digitos_value[3]), 15);

      // 2: bounce rejected, long hold gives a single digit
      s0 = n_strobe;
      press(4'd5, 3, 1);
      check("t2_bounce_rejected", int'(digitos_count), 0);
      mdl = {mdl[NUM_DIGITS-2:0], 4'd5};
      mcnt = 1;
      press(4'd5, 40, 6);
      check("t2_no_repeat_count", int'(digitos_count), 1);
      key(KEY_ENTER);
      check("t2_strobes", n_strobe - s0, 1);

      // 3: erase behaviour and ignored codes
      flush();
      s0 = n_strobe;
      key(4'd7); key(4'd8); key(KEY_ERASE);
      check("t3_count_after_erase", int'(digitos_count), 1);
      key(KEY_ERASE); key(KEY_ERASE);
      check("t3_erase_at_zero", int'(digitos_count), 0);
      key(KEY_ENTER);
      check("t3_empty_submit_no_strobe", n_strobe - s0, 0);
      key(4'd7); key(4'hC);
      check("t3_code_c_ignored", int'(digitos_count), 1);
      key(4'd8); key(KEY_ERASE); key(KEY_ENTER);
      check("t3_strobes", n_strobe - s0, 1);
      check("t3_digit0_is_7", int'(digitos_value[0]), 7);

      // 4: saturation at NUM_DIGITS, oldest dropped
      s0 = n_strobe;
      for (int r = 0; r < 2; r++)
         for (int d = 0; d < 10; d++) key(4'(d));
      key(4'd4);
      check("t4_count_saturated", int'(digitos_count), 20);
      key(KEY_ENTER);
      check("t4_strobes", n_strobe - s0, 1);
      check("t4_digit0", int'(digitos_value[0]), 4);
      check("t4_digit19_oldest_kept", int'(digitos_value[19]), 1);

      // 5: enable drop mid-press flushes and blocks the pending key
      s0 = n_strobe;
      key(4'd9);
      check("t5_count_before_drop", int'(digitos_count), 1);
      @(posedge clk); #1 tecla_value = 4'd6;
      @(posedge clk); #1 enable = 1'b0;
      @(posedge clk); #1 enable = 1'b1; tecla_value = KEY_NONE;
      mdl = SENHA_EMPTY;
      mcnt = 0;
      cycles(8);
      check("t5_flushed_no_6", int'(digitos_count), 0);
      key(4'd6); key(KEY_ENTER);
      check("t5_strobes", n_strobe - s0, 1);
      check("t5_digit0_is_6", int'(digitos_value[0]), 6);

      // 6: idle timeout (build dependent)
      s0 = n_strobe;
      key(4'd4);
      check("t6_count_before_idle", int'(digitos_count), 1);
      cycles(1010);
`ifdef KEYPAD_TIMEOUT_EN
      check("t6_timeout_flush", int'(digitos_count), 0);
`else
      check("t6_entry_persists", int'(digitos_count), 1);
`endif
      check("t6_no_strobe", n_strobe - s0, 0);
      flush();

      // reset mid-debounce discards everything
      s0 = n_strobe;
      key(4'd3);
      @(posedge clk); #1 tecla_value = 4'd2;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_count", int'(digitos_count), 0);
      check("rst_mid_valid", int'(digitos_valid), 0);
      check("rst_mid_value_empty", int'(digitos_value === SENHA_EMPTY), 1);
      rst = 1'b1;
      tecla_value = KEY_NONE;
      mdl = SENHA_EMPTY;
      mcnt = 0;
      cycles(12);
      check("rst_no_event_count", int'(digitos_count), 0);
      check("rst_no_strobe", n_strobe - s0, 0);

      cycles(5);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
